// File: rtl/exe_pkg.sv
// Shared types for the execution-unit issue controller.
package exe_pkg;

  // Execution unit opcode encoding
  typedef enum logic [1:0] {
    OP_SUB    = 2'b00,
    OP_CMP    = 2'b01,
    OP_SHIFT  = 2'b10,
    OP_BITCHG = 2'b11
  } op_e;

  localparam int unsigned STATUS_W = 4;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/exe_issue_ctrl.sv
// Issue controller: accepts a command, drives the execution unit, waits its fixed
// latency, captures result/status and returns them on a valid/ready response port.
module exe_issue_ctrl
  import exe_pkg::*;
#(
  parameter int unsigned BITS    = 8,
  parameter int unsigned EXE_LAT = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [BITS-1:0]     i_cmd_a,
  input  logic [BITS-1:0]     i_cmd_b,
  input  logic [1:0]          i_cmd_op,
  output logic [BITS-1:0]     o_exe_a,
  output logic [BITS-1:0]     o_exe_b,
  output logic [1:0]          o_exe_op,
  input  logic [BITS-1:0]     i_exe_out,
  input  logic [STATUS_W-1:0] i_exe_status,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [BITS-1:0]     o_rsp_data,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [1:0]          o_rsp_op,
  output logic [STATUS_W-1:0] o_sticky_status,
  input  logic                i_sticky_clr,
  output logic [CNT_W-1:0]    o_rsp_cnt,
  output logic                o_busy
);

  // EXE_LAT is at most 7, so three bits hold the wait count
  localparam int unsigned WaitW = 3;

  state_e                state_q, state_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [BITS-1:0]       exe_a_q, exe_a_d;
  logic [BITS-1:0]       exe_b_q, exe_b_d;
  logic [1:0]            exe_op_q, exe_op_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic [BITS-1:0]       rsp_data_q, rsp_data_d;
  logic [STATUS_W-1:0]   rsp_status_q, rsp_status_d;
  logic [STATUS_W-1:0]   sticky_q, sticky_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic accept, capture, rsp_hs;

  assign accept  = (state_q == IDLE) && i_cmd_valid;
  assign capture = (state_q == WAIT) && (wait_q == '0);
  assign rsp_hs  = (state_q == RESP) && i_rsp_ready;

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      exe_a_q      <= '0;
      exe_b_q      <= '0;
      exe_op_q     <= '0;
      rsp_op_q     <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      sticky_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      exe_a_q      <= exe_a_d;
      exe_b_q      <= exe_b_d;
      exe_op_q     <= exe_op_d;
      rsp_op_q     <= rsp_op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_cmd_valid) state_d = WAIT;
      WAIT:    if (wait_q == '0) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: command latch, wait counter, capture, sticky, response count
  always_comb begin
    wait_d       = wait_q;
    exe_a_d      = exe_a_q;
    exe_b_d      = exe_b_q;
    exe_op_d     = exe_op_q;
    rsp_op_d     = rsp_op_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    sticky_d     = sticky_q;
    cnt_d        = cnt_q;

    if (accept) begin
      exe_a_d  = i_cmd_a;
      exe_b_d  = i_cmd_b;
      exe_op_d = i_cmd_op;
      rsp_op_d = i_cmd_op;
      wait_d   = WaitW'(EXE_LAT);
    end else if (state_q == WAIT && wait_q != '0) begin
      wait_d = wait_q - 1'b1;
    end

    if (capture) begin
      rsp_data_d   = i_exe_out;
      rsp_status_d = i_exe_status;
      // A clear in the capture cycle wipes old history but keeps the new status
      sticky_d     = (i_sticky_clr ? '0 : sticky_q) | i_exe_status;
    end else if (i_sticky_clr) begin
      sticky_d = '0;
    end

    if (rsp_hs) cnt_d = cnt_q + 1'b1;
  end

  // Outputs decoded from state; ready is held low for the whole reset
  always_comb begin
    o_cmd_ready = (state_q == IDLE) && !i_rst;
    o_rsp_valid = (state_q == RESP);
    o_busy      = (state_q != IDLE);
  end

  assign o_exe_a         = exe_a_q;
  assign o_exe_b         = exe_b_q;
  assign o_exe_op        = exe_op_q;
  assign o_rsp_data      = rsp_data_q;
  assign o_rsp_status    = rsp_status_q;
  assign o_rsp_op        = rsp_op_q;
  assign o_sticky_status = sticky_q;
  assign o_rsp_cnt       = cnt_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench: default-latency controller with a 1-cycle unit model, and a
// latency-3 / 2-bit-counter controller with a 3-stage unit model.
module tb_exe_issue_ctrl;
  import exe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] unit_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
    logic [7:0] one;
    one = 8'd1;
    case (op)
      2'b00, 2'b01: unit_model = a - b;
      2'b10:        unit_model = a << 1;
      default:      unit_model = a ^ (one << b[2:0]);
    endcase
  endfunction

  // ---------------- DUT A: EXE_LAT=1, CNT_W=8 ----------------
  logic       a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready, a_sticky_clr, a_busy;
  logic [7:0] a_cmd_a, a_cmd_b, a_exe_a, a_exe_b, a_exe_out, a_rsp_data, a_rsp_cnt;
  logic [1:0] a_cmd_op, a_exe_op, a_rsp_op;
  logic [3:0] a_stat, a_rsp_status, a_sticky;

  exe_issue_ctrl u_dut_a (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (a_cmd_valid),
    .o_cmd_ready    (a_cmd_ready),
    .i_cmd_a        (a_cmd_a),
    .i_cmd_b        (a_cmd_b),
    .i_cmd_op       (a_cmd_op),
    .o_exe_a        (a_exe_a),
    .o_exe_b        (a_exe_b),
    .o_exe_op       (a_exe_op),
    .i_exe_out      (a_exe_out),
    .i_exe_status   (a_stat),
    .o_rsp_valid    (a_rsp_valid),
    .i_rsp_ready    (a_rsp_ready),
    .o_rsp_data     (a_rsp_data),
    .o_rsp_status   (a_rsp_status),
    .o_rsp_op       (a_rsp_op),
    .o_sticky_status(a_sticky),
    .i_sticky_clr   (a_sticky_clr),
    .o_rsp_cnt      (a_rsp_cnt),
    .o_busy         (a_busy)
  );

  // Latency-1 unit: result registered one edge after operands
  always @(posedge clk) a_exe_out <= unit_model(a_exe_a, a_exe_b, a_exe_op);

  // ---------------- DUT B: EXE_LAT=3, CNT_W=2 ----------------
  logic       b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready, b_busy;
  logic [7:0] b_cmd_a, b_cmd_b, b_exe_a, b_exe_b, b_exe_out, b_rsp_data;
  logic [7:0] b_p1, b_p2, b_p3;
  logic [1:0] b_cmd_op, b_exe_op, b_rsp_op, b_rsp_cnt;
  logic [3:0] b_rsp_status, b_sticky;

  exe_issue_ctrl #(.EXE_LAT(3), .CNT_W(2)) u_dut_b (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cmd_valid    (b_cmd_valid),
    .o_cmd_ready    (b_cmd_ready),
    .i_cmd_a        (b_cmd_a),
    .i_cmd_b        (b_cmd_b),
    .i_cmd_op       (b_cmd_op),
    .o_exe_a        (b_exe_a),
    .o_exe_b        (b_exe_b),
    .o_exe_op       (b_exe_op),
    .i_exe_out      (b_exe_out),
    .i_exe_status   (4'h0),
    .o_rsp_valid    (b_rsp_valid),
    .i_rsp_ready    (b_rsp_ready),
    .o_rsp_data     (b_rsp_data),
    .o_rsp_status   (b_rsp_status),
    .o_rsp_op       (b_rsp_op),
    .o_sticky_status(b_sticky),
    .i_sticky_clr   (1'b0),
    .o_rsp_cnt      (b_rsp_cnt),
    .o_busy         (b_busy)
  );

  // Latency-3 unit: three-stage result pipeline
  always @(posedge clk) begin
    b_p1 <= unit_model(b_exe_a, b_exe_b, b_exe_op);
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign b_exe_out = b_p3;

  // Present a command on A for one accepting edge; returns 1ns into cycle T+1
  task automatic a_issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [3:0] st);
    @(posedge clk); #1;
    a_cmd_valid = 1'b1; a_cmd_a = a; a_cmd_b = b; a_cmd_op = op; a_stat = st;
    @(negedge clk);
    check("a_accept_ready", 32'(a_cmd_ready), 1);
    @(posedge clk); #1;
    a_cmd_valid = 1'b0; a_cmd_a = 8'hEE; a_cmd_b = 8'hEE;
  endtask

  // One command on B; checks response timing T+5, data and counter after handshake
  task automatic b_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                       input logic [1:0] exp_cnt);
    @(posedge clk); #1;
    b_cmd_valid = 1'b1; b_cmd_a = a; b_cmd_b = b; b_cmd_op = OP_SUB;
    @(negedge clk);
    check("b_accept_ready", 32'(b_cmd_ready), 1);
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("b_no_valid_T+%0d", i), 32'(b_rsp_valid), 0);
    end
    @(negedge clk);
    check("b_valid_T+5", 32'(b_rsp_valid), 1);
    check("b_data", 32'(b_rsp_data), 32'(exp));
    @(negedge clk);
    check("b_cnt", 32'(b_rsp_cnt), 32'(exp_cnt));
    check("b_idle_ready", 32'(b_cmd_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    a_cmd_valid = 0; a_cmd_a = 0; a_cmd_b = 0; a_cmd_op = 0; a_stat = 0;
    a_rsp_ready = 0; a_sticky_clr = 0;
    b_cmd_valid = 0; b_cmd_a = 0; b_cmd_b = 0; b_cmd_op = 0; b_rsp_ready = 1;

    // Reset state
    #2;
    check("rst_cmd_ready", 32'(a_cmd_ready), 0);
    check("rst_rsp_valid", 32'(a_rsp_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_cnt", 32'(a_rsp_cnt), 0);
    check("rst_sticky", 32'(a_sticky), 0);
    check("rst_b_ready", 32'(b_cmd_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(a_cmd_ready), 1);

    // Basic SUB: 91-41=50, response in T+3
    a_rsp_ready = 1'b1;
    a_issue(8'd91, 8'd41, OP_SUB, 4'b0001);
    @(negedge clk);
    check("wait_busy", 32'(a_busy), 1);
    check("wait_not_ready", 32'(a_cmd_ready), 0);
    check("wait_no_valid", 32'(a_rsp_valid), 0);
    check("exe_a", 32'(a_exe_a), 91);
    check("exe_b", 32'(a_exe_b), 41);
    @(negedge clk);
    check("T+2_no_valid", 32'(a_rsp_valid), 0);
    @(negedge clk);
    check("T+3_valid", 32'(a_rsp_valid), 1);
    check("T+3_data", 32'(a_rsp_data), 50);
    check("T+3_op", 32'(a_rsp_op), 0);
    check("T+3_status", 32'(a_rsp_status), 32'h1);
    check("T+3_sticky", 32'(a_sticky), 32'h1);
    check("T+3_cnt", 32'(a_rsp_cnt), 0);
    @(negedge clk);
    check("after_hs_cnt", 32'(a_rsp_cnt), 1);
    check("after_hs_valid", 32'(a_rsp_valid), 0);
    check("after_hs_ready", 32'(a_cmd_ready), 1);
    check("exe_a_hold", 32'(a_exe_a), 91);

    // Backpressure: 10-3=7, status 0100, held 5 cycles
    a_rsp_ready = 1'b0;
    a_issue(8'd10, 8'd3, OP_SUB, 4'b0100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(a_rsp_valid), 1);
      check("bp_data", 32'(a_rsp_data), 7);
      check("bp_status", 32'(a_rsp_status), 32'h4);
      check("bp_op", 32'(a_rsp_op), 0);
      check("bp_not_ready", 32'(a_cmd_ready), 0);
      a_cmd_valid = 1'b1; // must be ignored outside IDLE
      @(negedge clk);
    end
    a_cmd_valid = 1'b0;
    check("bp_sticky", 32'(a_sticky), 32'h5);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(a_cmd_ready), 1);
    check("bp_release_valid", 32'(a_rsp_valid), 0);
    check("bp_cnt", 32'(a_rsp_cnt), 2);

    // Sticky clear coinciding with capture of 1000
    a_issue(8'd1, 8'd1, OP_CMP, 4'b1000);
    @(posedge clk); #1 a_sticky_clr = 1'b1;
    @(posedge clk); #1 a_sticky_clr = 1'b0;
    @(negedge clk);
    check("clr_cap_valid", 32'(a_rsp_valid), 1);
    check("clr_cap_sticky", 32'(a_sticky), 32'h8);
    check("clr_cap_op", 32'(a_rsp_op), 1);
    @(negedge clk);
    a_stat = 4'hF; // idle: status input must not be sampled
    @(negedge clk);
    check("idle_sticky", 32'(a_sticky), 32'h8);
    a_sticky_clr = 1'b1;
    @(negedge clk);
    a_sticky_clr = 1'b0;
    check("clr_alone", 32'(a_sticky), 0);

    // Reset one cycle after accept
    a_issue(8'd50, 8'd20, OP_SUB, 4'h2);
    rst = 1'b1;
    #1;
    check("rstw_exe_a", 32'(a_exe_a), 0);
    check("rstw_busy", 32'(a_busy), 0);
    check("rstw_ready", 32'(a_cmd_ready), 0);
    check("rstw_cnt", 32'(a_rsp_cnt), 0);
    check("rstw_data", 32'(a_rsp_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstw_no_rsp", 32'(a_rsp_valid), 0);
      check("rstw_ready_after", 32'(a_cmd_ready), 1);
    end

    // Latency 3 and 2-bit counter wrap
    b_run(8'd5, 8'd2, 8'd3, 2'd1);
    b_run(8'd20, 8'd4, 8'd16, 2'd2);
    b_run(8'd9, 8'd9, 8'd0, 2'd3);
    b_run(8'd100, 8'd1, 8'd99, 2'd0);
    b_run(8'd7, 8'd8, 8'd255, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
